mem_rr_arbiter: RTL
===================

Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the shared cache/DRAM Memory block.
- Lets two processor instances share one Memory port: latches the winning request, drives the memory handshake and waits for done.
- Returns read data to the owner, with a watchdog timeout and per-requester grant statistics.
- Sits between the processors and Memory, in place of the direct processor-to-Memory connection.

Parameters:
- DATA_W, 32, width of instruction/address word and returned data
- TIMEOUT, 255, max WAIT cycles before abort (1..65535)
- CNT_W, 16, width of per-requester grant counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request level
- ins0  in  DATA_W  requester 0 instruction/address, valid while req0=1
- rdata0  out  DATA_W  data returned to requester 0
- done0  out  1  one-cycle completion pulse to requester 0
- err0  out  1  one-cycle timeout flag, coincident with done0
- req1, ins1, rdata1, done1, err1  same as above for requester 1
- mem_req  out  1  request level to Memory
- mem_ins  out  DATA_W  registered instruction to Memory
- mem_rdata  in  DATA_W  Memory read data, valid with mem_done
- mem_done  in  1  Memory completion pulse
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in WAIT or RESP
- gnt_cnt0  out  CNT_W  completed grants to requester 0, saturating
- gnt_cnt1  out  CNT_W  completed grants to requester 1, saturating
- timeout_cnt  out  8  total timeouts, saturating at 255

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0: rdata*, done*, err*, mem_req, mem_ins, grant, busy, gnt_cnt*, timeout_cnt.
  - Round-robin pointer last=1, so requester 0 wins first.
  - Watchdog cleared.
- All outputs are registered.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Only req0: select 0. Only req1: select 1.
  - Both: select the requester != last.
  - On select, at that edge: mem_ins <= ins of winner; grant <= one-hot winner; mem_req <= 1; busy <= 1; watchdog <= 0; go WAIT.
  - mem_req is first visible the cycle after req is sampled.
- WAIT:
  - mem_req held 1; mem_ins and grant stable; watchdog increments each cycle.
  - mem_done=1: capture mem_rdata into rdata of the owner; err_pending=0; mem_req <= 0; go RESP.
  - Otherwise, watchdog reaches TIMEOUT-1 with no done: rdata unchanged; err_pending=1; mem_req <= 0; go RESP.
  - mem_done and watchdog expiry in the same cycle: done wins, no error.
  - Requester dropping req during WAIT does not abort; the transaction completes and done still pulses.
- RESP (exactly one cycle):
  - done<owner>=1; err<owner>=err_pending.
  - last <= owner.
  - If no error: gnt_cnt<owner> += 1, saturating at all-ones. If error: timeout_cnt += 1, saturating.
  - Next edge: grant <= 00, busy <= 0, done/err <= 0; go IDLE.
- rdata<k> holds its last value until the next successful transaction for k.
- mem_done in IDLE or RESP is ignored and not stored.
- Throughput:
  - Minimum 3 cycles per transaction (IDLE, WAIT with immediate done, RESP).
  - With both reqs held high, grants alternate 0,1,0,1.
- A requester keeping req high after done is re-arbitrated normally. It must deassert to avoid a repeat access.
- Reset mid-transaction (any state): immediate return to IDLE; mem_req drops; no done/err pulse; counters cleared.
- ins0/ins1 changes after grant do not affect mem_ins.

Test Plan:
- Reset then single request: rst pulse; req0=1, ins0=32'h0000_1234; Memory returns mem_rdata=32'hCAFE_0001 3 cycles after mem_req -> mem_ins=32'h1234, grant=01, done0 one cycle with rdata0=32'hCAFE_0001, err0=0, gnt_cnt0=1, busy low after RESP.
- Contention fairness: req0=req1=1 held for 6 transactions, mem_done 1 cycle after mem_req -> grant order 01,10,01,10,01,10; gnt_cnt0=gnt_cnt1=3; never both done0 and done1 in the same cycle.
- Timeout: TIMEOUT=8, req1=1, mem_done never asserted -> mem_req high exactly 8 cycles; done1=err1=1 for one cycle; rdata1 unchanged; timeout_cnt=1; gnt_cnt1 unchanged.
- Done/timeout collision: TIMEOUT=8, mem_done on the 8th WAIT cycle -> err0=0; rdata0 updated; gnt_cnt0 increments; timeout_cnt unchanged.
- Reset mid-WAIT: assert rst 2 cycles into WAIT -> mem_req, grant, busy drop to 0 immediately; no done pulse; after release with req1=1, req0=1, requester 0 wins first.
- Saturation and spurious done: CNT_W=2; 5 successful req0 transactions plus mem_done pulses while IDLE -> gnt_cnt0 stops at 3; spurious mem_done produces no done0 and no state change.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared Memory port.
// Latches the winner, runs the memory handshake with a watchdog, keeps stats.
module mem_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] ins0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic [DATA_W-1:0] ins1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              err1,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_ins,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [7:0]        timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last;
  logic        err_pend;
  logic [15:0] wd;
  logic        take;
  logic        pick;
  logic        owner;

  // Owner is the high grant bit; valid whenever grant is non-zero.
  assign owner = grant[1];

  always_comb begin
    take = req0 | req1;
    pick = (req0 & req1) ? ~last : req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      err_pend    <= 1'b0;
      wd          <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      mem_req     <= 1'b0;
      mem_ins     <= '0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      gnt_cnt0    <= '0;
      gnt_cnt1    <= '0;
      timeout_cnt <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            mem_ins <= pick ? ins1 : ins0;
            grant   <= pick ? 2'b10 : 2'b01;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            wd      <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          wd <= wd + 16'd1;
          // A done in the expiry cycle still counts as success.
          if (mem_done) begin
            if (owner) begin
              rdata1 <= mem_rdata;
              done1  <= 1'b1;
            end else begin
              rdata0 <= mem_rdata;
              done0  <= 1'b1;
            end
            err_pend <= 1'b0;
            mem_req  <= 1'b0;
            state    <= RESP;
          end else if (wd == WD_MAX) begin
            if (owner) begin
              done1 <= 1'b1;
              err1  <= 1'b1;
            end else begin
              done0 <= 1'b1;
              err0  <= 1'b1;
            end
            err_pend <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          last <= owner;
          if (err_pend) begin
            if (timeout_cnt != 8'hFF)
              timeout_cnt <= timeout_cnt + 8'd1;
          end else if (owner) begin
            if (gnt_cnt1 != '1)
              gnt_cnt1 <= gnt_cnt1 + 1'b1;
          end else begin
            if (gnt_cnt0 != '1)
              gnt_cnt0 <= gnt_cnt0 + 1'b1;
          end
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
